// File: rtl/controle_vedacao.sv
// Corking-station controller: presses one cork per bottle, pulses the cork counter's
// decrement, and runs the refill/parallel-load handshake when the counter runs dry.
module controle_vedacao #(
  parameter logic [6:0]  REFILL_QTY   = 7'd99,
  parameter int unsigned PRESS_CYCLES = 4,
  parameter int unsigned LOW_MARK     = 5
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        GARRAFA_OK,
  input  logic [6:0]  COUNT,
  input  logic        ZERO,
  input  logic        REPOSICAO_ACK,
  output logic        ENABLE,
  output logic        LOAD,
  output logic [6:0]  DADOS,
  output logic        PRENSA,
  output logic        GARRAFA_PRONTA,
  output logic        PEDIDO_REPOSICAO,
  output logic        ALERTA_BAIXO,
  output logic [15:0] TOTAL_VEDADAS
);

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned COUNT_W = 7;
  localparam int unsigned TOTAL_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    WAIT_REMOVE,
    REFILL_REQ,
    REFILL_LOAD,
    SETTLE
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;

  // Single registered FSM; pulse outputs default low every cycle.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state            <= IDLE;
      timer            <= '0;
      ENABLE           <= 1'b0;
      LOAD             <= 1'b0;
      DADOS            <= '0;
      PRENSA           <= 1'b0;
      GARRAFA_PRONTA   <= 1'b0;
      PEDIDO_REPOSICAO <= 1'b0;
      ALERTA_BAIXO     <= 1'b0;
      TOTAL_VEDADAS    <= '0;
    end else begin
      ENABLE         <= 1'b0;
      LOAD           <= 1'b0;
      DADOS          <= '0;
      GARRAFA_PRONTA <= 1'b0;
      ALERTA_BAIXO   <= (COUNT <= COUNT_W'(LOW_MARK)) && !ZERO;

      case (state)
        IDLE: begin
          // An empty magazine wins over a waiting bottle, so no cork is fired on ZERO.
          if (ZERO) begin
            state            <= REFILL_REQ;
            PEDIDO_REPOSICAO <= 1'b1;
          end else if (GARRAFA_OK) begin
            state  <= PRESS;
            ENABLE <= 1'b1;
            PRENSA <= 1'b1;
            timer  <= TIMER_W'(1);
          end
        end
        PRESS: begin
          if (timer == TIMER_W'(PRESS_CYCLES)) begin
            state          <= WAIT_REMOVE;
            PRENSA         <= 1'b0;
            GARRAFA_PRONTA <= 1'b1;
            TOTAL_VEDADAS  <= TOTAL_VEDADAS + TOTAL_W'(1);
            timer          <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        WAIT_REMOVE: begin
          if (!GARRAFA_OK) state <= IDLE;
        end
        REFILL_REQ: begin
          if (REPOSICAO_ACK) begin
            state            <= REFILL_LOAD;
            LOAD             <= 1'b1;
            DADOS            <= REFILL_QTY;
            PEDIDO_REPOSICAO <= 1'b0;
          end
        end
        REFILL_LOAD: state <= SETTLE;
        // Gives the counter one cycle to clear ZERO after the load.
        SETTLE:      state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_vedacao.sv
// Directed bench for controle_vedacao with a simple cork-counter model for closed-loop runs.
module tb_controle_vedacao;

  logic        CLOCK;
  logic        RESET;
  logic        GARRAFA_OK;
  logic [6:0]  COUNT;
  logic        ZERO;
  logic        REPOSICAO_ACK;
  logic        ENABLE;
  logic        LOAD;
  logic [6:0]  DADOS;
  logic        PRENSA;
  logic        GARRAFA_PRONTA;
  logic        PEDIDO_REPOSICAO;
  logic        ALERTA_BAIXO;
  logic [15:0] TOTAL_VEDADAS;

  logic        use_model;
  logic [6:0]  cnt_drv;
  logic        zero_drv;
  logic [6:0]  model_cnt;
  logic        preset_en;
  logic [6:0]  preset_val;

  int errors = 0;
  int checks = 0;
  int en_pulses = 0;
  int load_pulses = 0;
  int viol = 0;

  controle_vedacao dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .GARRAFA_OK       (GARRAFA_OK),
    .COUNT            (COUNT),
    .ZERO             (ZERO),
    .REPOSICAO_ACK    (REPOSICAO_ACK),
    .ENABLE           (ENABLE),
    .LOAD             (LOAD),
    .DADOS            (DADOS),
    .PRENSA           (PRENSA),
    .GARRAFA_PRONTA   (GARRAFA_PRONTA),
    .PEDIDO_REPOSICAO (PEDIDO_REPOSICAO),
    .ALERTA_BAIXO     (ALERTA_BAIXO),
    .TOTAL_VEDADAS    (TOTAL_VEDADAS)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  assign COUNT = use_model ? model_cnt : cnt_drv;
  assign ZERO  = use_model ? (model_cnt == 7'd0) : zero_drv;

  // Cork counter model: load has priority over decrement.
  always @(posedge CLOCK) begin
    if (preset_en)   model_cnt <= preset_val;
    else if (LOAD)   model_cnt <= DADOS;
    else if (ENABLE) model_cnt <= model_cnt - 7'd1;
  end

  always @(negedge CLOCK) begin
    if (ENABLE) en_pulses++;
    if (LOAD) load_pulses++;
    if (ENABLE && LOAD) viol++;
    if (ENABLE && ZERO) viol++;
  end

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset;
    RESET = 1'b0;
    GARRAFA_OK = 1'b0;
    REPOSICAO_ACK = 1'b0;
    use_model = 1'b0;
    cnt_drv = 7'd20;
    zero_drv = 1'b0;
    preset_en = 1'b0;
    repeat (2) tick;
    RESET = 1'b1;
    tick;
  endtask

  task automatic preset_model(input logic [6:0] v);
    use_model = 1'b0;
    preset_val = v;
    preset_en = 1'b1;
    tick;
    preset_en = 1'b0;
    use_model = 1'b1;
  endtask

  task automatic test_reset;
    logic [32:0] outs;
    RESET = 1'b0;
    GARRAFA_OK = 1'b0;
    REPOSICAO_ACK = 1'b0;
    use_model = 1'b0;
    cnt_drv = 7'd20;
    zero_drv = 1'b0;
    preset_en = 1'b0;
    #2;
    outs = {ENABLE, LOAD, DADOS, PRENSA, GARRAFA_PRONTA, PEDIDO_REPOSICAO, ALERTA_BAIXO, TOTAL_VEDADAS};
    checks++;
    if (outs !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    repeat (2) tick;
    RESET = 1'b1;
    tick;
  endtask

  task automatic test_single_bottle;
    int e0;
    do_reset;
    GARRAFA_OK = 1'b1;
    e0 = en_pulses;
    tick;
    checks++;
    if ({ENABLE, PRENSA} !== 2'b11) begin
      errors++;
      $display("FAIL first_press: ENABLE,PRENSA got %b expected 11", {ENABLE, PRENSA});
    end
    tick;
    checks++;
    if ({ENABLE, PRENSA} !== 2'b01) begin
      errors++;
      $display("FAIL press_cycle2: ENABLE,PRENSA got %b expected 01", {ENABLE, PRENSA});
    end
    repeat (2) tick;
    checks++;
    if (PRENSA !== 1'b1) begin
      errors++;
      $display("FAIL press_cycle4: PRENSA got %b expected 1", PRENSA);
    end
    tick;
    checks++;
    if ({PRENSA, GARRAFA_PRONTA} !== 2'b01 || TOTAL_VEDADAS !== 16'd1) begin
      errors++;
      $display("FAIL sealed: PRENSA,PRONTA got %b expected 01, TOTAL got %0d expected 1",
               {PRENSA, GARRAFA_PRONTA}, TOTAL_VEDADAS);
    end
    tick;
    checks++;
    if (GARRAFA_PRONTA !== 1'b0) begin
      errors++;
      $display("FAIL pronta_pulse: GARRAFA_PRONTA got %b expected 0", GARRAFA_PRONTA);
    end
    repeat (6) tick;
    checks++;
    if (en_pulses - e0 != 1) begin
      errors++;
      $display("FAIL one_cork: ENABLE pulses got %0d expected 1", en_pulses - e0);
    end
    GARRAFA_OK = 1'b0;
    tick;
    GARRAFA_OK = 1'b1;
    tick;
    checks++;
    if (ENABLE !== 1'b1) begin
      errors++;
      $display("FAIL next_bottle: ENABLE got %b expected 1", ENABLE);
    end
    repeat (4) tick;
    checks++;
    if (GARRAFA_PRONTA !== 1'b1 || TOTAL_VEDADAS !== 16'd2) begin
      errors++;
      $display("FAIL second_seal: PRONTA got %b expected 1, TOTAL got %0d expected 2",
               GARRAFA_PRONTA, TOTAL_VEDADAS);
    end
    GARRAFA_OK = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_refill;
    int e0;
    do_reset;
    cnt_drv = 7'd0;
    zero_drv = 1'b1;
    GARRAFA_OK = 1'b1;
    e0 = en_pulses;
    tick;
    checks++;
    if ({ENABLE, PEDIDO_REPOSICAO} !== 2'b01) begin
      errors++;
      $display("FAIL refill_req: ENABLE,PEDIDO got %b expected 01", {ENABLE, PEDIDO_REPOSICAO});
    end
    repeat (3) tick;
    checks++;
    if (PEDIDO_REPOSICAO !== 1'b1 || en_pulses != e0) begin
      errors++;
      $display("FAIL refill_hold: PEDIDO got %b expected 1, ENABLE pulses got %0d expected 0",
               PEDIDO_REPOSICAO, en_pulses - e0);
    end
    REPOSICAO_ACK = 1'b1;
    tick;
    checks++;
    if (LOAD !== 1'b1 || DADOS !== 7'd99 || PEDIDO_REPOSICAO !== 1'b0) begin
      errors++;
      $display("FAIL refill_load: LOAD got %b exp 1, DADOS got %0d exp 99, PEDIDO got %b exp 0",
               LOAD, DADOS, PEDIDO_REPOSICAO);
    end
    REPOSICAO_ACK = 1'b0;
    cnt_drv = 7'd99;
    zero_drv = 1'b0;
    GARRAFA_OK = 1'b0;
    tick;
    checks++;
    if (LOAD !== 1'b0 || DADOS !== 7'd0) begin
      errors++;
      $display("FAIL load_pulse: LOAD got %b expected 0, DADOS got %0d expected 0", LOAD, DADOS);
    end
    tick;
    GARRAFA_OK = 1'b1;
    tick;
    checks++;
    if (ENABLE !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_settle: ENABLE got %b expected 1", ENABLE);
    end
    repeat (4) tick;
    GARRAFA_OK = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_closed_loop;
    logic [6:0] exp_cnt [3];
    int l0;
    logic got;
    exp_cnt[0] = 7'd1;
    exp_cnt[1] = 7'd0;
    exp_cnt[2] = 7'd98;
    do_reset;
    preset_model(7'd2);
    l0 = load_pulses;
    for (int b = 0; b < 3; b++) begin
      GARRAFA_OK = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        tick;
        REPOSICAO_ACK = PEDIDO_REPOSICAO;
        if (GARRAFA_PRONTA) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL loop_timeout: bottle %0d got no GARRAFA_PRONTA expected one", b);
      end
      checks++;
      if (COUNT !== exp_cnt[b]) begin
        errors++;
        $display("FAIL loop_count: bottle %0d COUNT got %0d expected %0d", b, COUNT, exp_cnt[b]);
      end
      GARRAFA_OK = 1'b0;
      REPOSICAO_ACK = 1'b0;
      repeat (2) tick;
    end
    checks++;
    if (TOTAL_VEDADAS !== 16'd3 || load_pulses - l0 != 1) begin
      errors++;
      $display("FAIL loop_total: TOTAL got %0d expected 3, LOAD pulses got %0d expected 1",
               TOTAL_VEDADAS, load_pulses - l0);
    end
  endtask

  task automatic test_alerta;
    do_reset;
    cnt_drv = 7'd6;
    tick;
    checks++;
    if (ALERTA_BAIXO !== 1'b0) begin
      errors++;
      $display("FAIL alerta_6: got %b expected 0", ALERTA_BAIXO);
    end
    cnt_drv = 7'd5;
    #1;
    checks++;
    if (ALERTA_BAIXO !== 1'b0) begin
      errors++;
      $display("FAIL alerta_latency: got %b expected 0", ALERTA_BAIXO);
    end
    tick;
    checks++;
    if (ALERTA_BAIXO !== 1'b1) begin
      errors++;
      $display("FAIL alerta_5: got %b expected 1", ALERTA_BAIXO);
    end
    cnt_drv = 7'd0;
    zero_drv = 1'b1;
    tick;
    checks++;
    if (ALERTA_BAIXO !== 1'b0) begin
      errors++;
      $display("FAIL alerta_zero: got %b expected 0", ALERTA_BAIXO);
    end
  endtask

  task automatic test_reset_mid_press;
    logic [32:0] outs;
    do_reset;
    GARRAFA_OK = 1'b1;
    repeat (5) tick;
    checks++;
    if (TOTAL_VEDADAS !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset_total: got %0d expected 1", TOTAL_VEDADAS);
    end
    GARRAFA_OK = 1'b0;
    repeat (2) tick;
    GARRAFA_OK = 1'b1;
    repeat (2) tick;
    RESET = 1'b0;
    #1;
    outs = {ENABLE, LOAD, DADOS, PRENSA, GARRAFA_PRONTA, PEDIDO_REPOSICAO, ALERTA_BAIXO, TOTAL_VEDADAS};
    checks++;
    if (outs !== 33'd0) begin
      errors++;
      $display("FAIL async_reset: outputs got %h expected 0", outs);
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    tick;
    checks++;
    if ({ENABLE, PRENSA} !== 2'b11) begin
      errors++;
      $display("FAIL repress: ENABLE,PRENSA got %b expected 11", {ENABLE, PRENSA});
    end
    repeat (4) tick;
    checks++;
    if (GARRAFA_PRONTA !== 1'b1 || TOTAL_VEDADAS !== 16'd1) begin
      errors++;
      $display("FAIL repress_seal: PRONTA got %b expected 1, TOTAL got %0d expected 1",
               GARRAFA_PRONTA, TOTAL_VEDADAS);
    end
    GARRAFA_OK = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_ack_stuck;
    int l0;
    int e0;
    do_reset;
    preset_model(7'd0);
    REPOSICAO_ACK = 1'b1;
    l0 = load_pulses;
    repeat (8) tick;
    checks++;
    if (load_pulses - l0 != 1 || PEDIDO_REPOSICAO !== 1'b0 || COUNT !== 7'd99) begin
      errors++;
      $display("FAIL ack_stuck: LOAD pulses got %0d exp 1, PEDIDO got %b exp 0, COUNT got %0d exp 99",
               load_pulses - l0, PEDIDO_REPOSICAO, COUNT);
    end
    REPOSICAO_ACK = 1'b0;
    l0 = load_pulses;
    e0 = en_pulses;
    repeat (3) begin
      REPOSICAO_ACK = 1'b1;
      tick;
      REPOSICAO_ACK = 1'b0;
      tick;
    end
    GARRAFA_OK = 1'b1;
    tick;
    REPOSICAO_ACK = 1'b1;
    tick;
    REPOSICAO_ACK = 1'b0;
    tick;
    REPOSICAO_ACK = 1'b1;
    tick;
    REPOSICAO_ACK = 1'b0;
    tick;
    checks++;
    if (load_pulses != l0 || GARRAFA_PRONTA !== 1'b1) begin
      errors++;
      $display("FAIL ack_ignored: LOAD pulses got %0d expected 0, PRONTA got %b expected 1",
               load_pulses - l0, GARRAFA_PRONTA);
    end
    GARRAFA_OK = 1'b0;
    repeat (2) tick;
    checks++;
    if (en_pulses - e0 != 1 || COUNT !== 7'd98) begin
      errors++;
      $display("FAIL ack_enable: ENABLE pulses got %0d expected 1, COUNT got %0d expected 98",
               en_pulses - e0, COUNT);
    end
  endtask

  task automatic test_exclusivity;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL exclusivity: ENABLE overlap events got %0d expected 0", viol);
    end
  endtask

  initial begin
    test_reset;
    test_single_bottle;
    test_refill;
    test_closed_loop;
    test_alerta;
    test_reset_mid_press;
    test_ack_stuck;
    test_exclusivity;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
